// File: rtl/mesh_terminal_agent.sv
// Mesh edge terminal stand-in: FWFT TX FIFO toward the router terminal,
// three-state RX drain of the router output port with destination check.
module mesh_terminal_agent #(
   parameter int         pckg_sz    = 40,
   parameter int         fifo_depth = 4,
   parameter logic [3:0] MY_ROW     = 4'd0,
   parameter logic [3:0] MY_COL     = 4'd0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_valid,
   output logic               tx_ready,
   input  logic [7:0]         tx_nxt_jump,
   input  logic [3:0]         tx_id_row,
   input  logic [3:0]         tx_id_col,
   input  logic               tx_mode,
   input  logic [pckg_sz-18:0] tx_dato,
   output logic               pndng_i_in,
   output logic [pckg_sz-1:0] data_out_i_in,
   input  logic               popin,
   input  logic               pndng,
   input  logic [pckg_sz-1:0] data_out,
   output logic               pop,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   output logic               rx_id_ok,
   output logic [15:0]        rx_count
);

   localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int CNT_W = $clog2(fifo_depth + 1);
   localparam int DW    = pckg_sz - 17;

   logic [pckg_sz-1:0] mem_q [fifo_depth];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               push, pull, full, empty;
   logic [pckg_sz-1:0] tx_pkt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full   = (cnt_q == CNT_W'(fifo_depth));
   assign empty  = (cnt_q == '0);
   assign push   = tx_valid && !full;
   assign pull   = popin && !empty;
   assign tx_pkt = {tx_nxt_jump, tx_id_row, tx_id_col, tx_mode, tx_dato};

   assign tx_ready      = !full;
   assign pndng_i_in    = !empty;
   assign data_out_i_in = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pull ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pull) cnt_d = cnt_q + CNT_W'(1);
      if (pull && !push) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is never reset; stale words are masked by the empty flag.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_pkt;
   end

   typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_WAIT} rx_state_t;

   rx_state_t          state_q, state_d;
   logic               pop_q, pop_d;
   logic               rx_valid_q, rx_valid_d;
   logic [pckg_sz-1:0] rx_data_q, rx_data_d;
   logic               rx_id_ok_q, rx_id_ok_d;
   logic [15:0]        rx_count_q, rx_count_d;
   logic               id_hit;

   assign id_hit = ((data_out[pckg_sz-9 -: 4] == MY_ROW) &&
                    (data_out[pckg_sz-13 -: 4] == MY_COL)) ||
                   (&data_out[DW-1:0]);

   always_comb begin
      state_d    = state_q;
      pop_d      = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_id_ok_d = rx_id_ok_q;
      rx_count_d = rx_count_q;
      unique case (state_q)
         RX_IDLE: begin
            if (pndng) begin
               state_d = RX_POP;
               pop_d   = 1'b1;
            end
         end
         RX_POP: begin
            state_d    = RX_WAIT;
            rx_data_d  = data_out;
            rx_id_ok_d = id_hit;
            rx_valid_d = 1'b1;
            if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
         end
         RX_WAIT: state_d = RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RX_IDLE;
         pop_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_id_ok_q <= 1'b0;
         rx_count_q <= '0;
      end else begin
         state_q    <= state_d;
         pop_q      <= pop_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         rx_id_ok_q <= rx_id_ok_d;
         rx_count_q <= rx_count_d;
      end
   end

   assign pop      = pop_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign rx_id_ok = rx_id_ok_q;
   assign rx_count = rx_count_q;

endmodule

// File: tb/tb_mesh_terminal_agent.sv
// Scoreboard bench for mesh_terminal_agent: TX FIFO ordering/full/reset,
// RX pop cadence, capture, destination check and counting.
module tb_mesh_terminal_agent;

   localparam logic [3:0] ROW = 4'd2;
   localparam logic [3:0] COL = 4'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_nxt_jump;
   logic [3:0]  tx_id_row;
   logic [3:0]  tx_id_col;
   logic        tx_mode;
   logic [22:0] tx_dato;
   logic        pndng_i_in;
   logic [39:0] data_out_i_in;
   logic        popin;
   logic        pndng;
   logic [39:0] data_out;
   logic        pop;
   logic        rx_valid;
   logic [39:0] rx_data;
   logic        rx_id_ok;
   logic [15:0] rx_count;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int exp_cnt = 0;
   logic [39:0] txq[$];
   logic [40:0] rxq[$];

   mesh_terminal_agent #(
      .pckg_sz(40), .fifo_depth(4), .MY_ROW(ROW), .MY_COL(COL)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_nxt_jump(tx_nxt_jump), .tx_id_row(tx_id_row),
      .tx_id_col(tx_id_col), .tx_mode(tx_mode), .tx_dato(tx_dato),
      .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
      .popin(popin), .pndng(pndng), .data_out(data_out), .pop(pop),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_id_ok(rx_id_ok),
      .rx_count(rx_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [39:0] pack(input logic [7:0] nj, input logic [3:0] r,
                                        input logic [3:0] c, input logic m,
                                        input logic [22:0] d);
      return {nj, r, c, m, d};
   endfunction

   function automatic logic idok(input logic [39:0] p);
      return ((p[31:28] == ROW) && (p[27:24] == COL)) || (p[22:0] == 23'h7FFFFF);
   endfunction

   // Drive one TX cycle from a negedge and update the reference FIFO.
   task automatic tx_step(input logic v, input logic [39:0] p, input logic pi);
      bit was_full;
      bit was_empty;
      was_full  = (txq.size() == 4);
      was_empty = (txq.size() == 0);
      tx_valid = v;
      {tx_nxt_jump, tx_id_row, tx_id_col, tx_mode, tx_dato} = p;
      popin = pi;
      if (pi && !was_empty) void'(txq.pop_front());
      if (v && !was_full) txq.push_back(p);
      @(negedge clk);
      tx_valid = 1'b0;
      popin    = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #50;
      nvec++; if (pndng_i_in !== 1'b0) begin nerr++; $display("FAIL reset_pndng_i_in got %0b exp 0", pndng_i_in); end
      nvec++; if (pop !== 1'b0) begin nerr++; $display("FAIL reset_pop got %0b exp 0", pop); end
      nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL reset_tx_ready got %0b exp 1", tx_ready); end
      nvec++; if (rx_count !== 16'd0) begin nerr++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
      nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_rx_valid got %0b exp 0", rx_valid); end
      nvec++; if (data_out_i_in !== 40'd0) begin nerr++; $display("FAIL reset_data_out_i_in got %h exp 0", data_out_i_in); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_tx;
      logic [39:0] e;
      tx_step(1'b1, pack(8'h00, 4'h1, 4'h2, 1'b1, 23'h5A5A5), 1'b0);
      e = txq[0];
      nvec++; if (pndng_i_in !== 1'b1) begin nerr++; $display("FAIL single_pndng got %0b exp 1", pndng_i_in); end
      nvec++; if (data_out_i_in !== e) begin nerr++; $display("FAIL single_head got %h exp %h", data_out_i_in, e); end
      tx_step(1'b0, '0, 1'b1);
      nvec++; if (pndng_i_in !== 1'b0) begin nerr++; $display("FAIL single_pop_pndng got %0b exp 0", pndng_i_in); end
      nvec++; if (data_out_i_in !== 40'd0) begin nerr++; $display("FAIL single_empty_data got %h exp 0", data_out_i_in); end
   endtask

   task automatic test_tx_full;
      logic [39:0] e;
      for (int i = 0; i < 5; i++) begin
         tx_step(1'b1, pack(8'(i + 1), 4'(i), 4'(3 - i), 1'(i), 23'($urandom)), 1'b0);
         nvec++; if (tx_ready !== (txq.size() < 4)) begin nerr++; $display("FAIL full_tx_ready[%0d] got %0b exp %0b", i, tx_ready, txq.size() < 4); end
      end
      for (int i = 0; i < 4; i++) begin
         e = txq[0];
         nvec++; if (data_out_i_in !== e) begin nerr++; $display("FAIL full_order[%0d] got %h exp %h", i, data_out_i_in, e); end
         tx_step(1'b0, '0, 1'b1);
      end
      nvec++; if (pndng_i_in !== 1'b0) begin nerr++; $display("FAIL full_drained got %0b exp 0", pndng_i_in); end
      tx_step(1'b0, '0, 1'b1);
      nvec++; if (tx_ready !== 1'b1 || pndng_i_in !== 1'b0) begin nerr++; $display("FAIL pop_empty got rdy=%0b pnd=%0b exp 1/0", tx_ready, pndng_i_in); end
   endtask

   task automatic test_push_pop;
      logic [39:0] e;
      tx_step(1'b1, pack(8'hA0, 4'h5, 4'h6, 1'b0, 23'($urandom)), 1'b0);
      tx_step(1'b1, pack(8'hA1, 4'h7, 4'h8, 1'b1, 23'($urandom)), 1'b0);
      for (int k = 0; k < 6; k++) begin
         e = txq[0];
         nvec++; if (data_out_i_in !== e) begin nerr++; $display("FAIL pp_head[%0d] got %h exp %h", k, data_out_i_in, e); end
         tx_step(1'b1, pack(8'(8'hB0 + k), 4'(k), 4'(k + 1), 1'(k), 23'($urandom)), 1'b1);
         nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL pp_ready[%0d] got %0b exp 1", k, tx_ready); end
      end
      for (int k = 0; k < 2; k++) begin
         e = txq[0];
         nvec++; if (data_out_i_in !== e) begin nerr++; $display("FAIL pp_tail[%0d] got %h exp %h", k, data_out_i_in, e); end
         tx_step(1'b0, '0, 1'b1);
      end
      nvec++; if (pndng_i_in !== 1'b0) begin nerr++; $display("FAIL pp_occupancy got pnd=%0b exp 0", pndng_i_in); end
   endtask

   task automatic test_rx(input logic [39:0] pkt, input int ncyc);
      int last;
      int npop;
      logic [40:0] e;
      last = -1;
      npop = 0;
      pndng = 1'b1;
      data_out = pkt;
      for (int i = 0; i < ncyc + 4; i++) begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            nvec++;
            if (rxq.size() == 0) begin
               nerr++; $display("FAIL rx_spurious_valid got 1 exp 0");
            end else begin
               e = rxq.pop_front();
               exp_cnt++;
               if (rx_data !== e[39:0] || rx_id_ok !== e[40] || rx_count !== 16'(exp_cnt)) begin
                  nerr++;
                  $display("FAIL rx_capture got %h ok=%0b cnt=%0d exp %h ok=%0b cnt=%0d",
                           rx_data, rx_id_ok, rx_count, e[39:0], e[40], exp_cnt);
               end
            end
         end
         if (pop === 1'b1) begin
            if (last >= 0) begin
               nvec++; if (cyc - last != 3) begin nerr++; $display("FAIL rx_pop_period got %0d exp 3", cyc - last); end
            end
            last = cyc;
            npop++;
            rxq.push_back({idok(pkt), pkt});
         end
         if (i == ncyc - 1) pndng = 1'b0;
      end
      nvec++; if (npop != (ncyc + 2) / 3 || rxq.size() != 0) begin nerr++; $display("FAIL rx_pops got %0d left=%0d exp %0d left=0", npop, rxq.size(), (ncyc + 2) / 3); end
   endtask

   task automatic test_reset_in_pop;
      bit seen;
      seen = 1'b0;
      tx_step(1'b1, pack(8'h11, 4'h2, 4'h2, 1'b0, 23'h1234), 1'b0);
      pndng = 1'b1;
      data_out = pack(8'h22, ROW, COL, 1'b0, 23'h42);
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clk);
         if (pop === 1'b1) seen = 1'b1;
      end
      nvec++; if (!seen) begin nerr++; $display("FAIL rip_pop_timeout got no pop exp pop within 5 cycles"); end
      #2 reset = 1'b1;
      #1;
      txq.delete();
      rxq.delete();
      exp_cnt = 0;
      nvec++; if (pop !== 1'b0) begin nerr++; $display("FAIL rip_pop got %0b exp 0", pop); end
      nvec++; if (rx_count !== 16'd0) begin nerr++; $display("FAIL rip_rx_count got %0d exp 0", rx_count); end
      nvec++; if (pndng_i_in !== 1'b0 || tx_ready !== 1'b1) begin nerr++; $display("FAIL rip_tx got pnd=%0b rdy=%0b exp 0/1", pndng_i_in, tx_ready); end
      nvec++; if (data_out_i_in !== 40'd0) begin nerr++; $display("FAIL rip_tx_data got %h exp 0", data_out_i_in); end
      pndng = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      nvec++; if (rx_valid !== 1'b0 || rx_count !== 16'd0) begin nerr++; $display("FAIL rip_after got v=%0b cnt=%0d exp 0/0", rx_valid, rx_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      tx_valid = 1'b0;
      {tx_nxt_jump, tx_id_row, tx_id_col, tx_mode, tx_dato} = '0;
      popin = 1'b0;
      pndng = 1'b0;
      data_out = '0;
      test_reset;
      test_single_tx;
      test_tx_full;
      test_push_pop;
      test_rx(pack(8'h33, ROW, COL, 1'b1, 23'h0ABCDE), 9);
      test_rx(pack(8'h44, 4'd3, 4'd3, 1'b0, 23'h000005), 6);
      test_rx(pack(8'h55, 4'd3, 4'd3, 1'b1, 23'h7FFFFF), 6);
      test_rx(pack(8'h66, ROW, 4'd3, 1'b0, 23'h7FFFFE), 3);
      test_reset_in_pop;
      test_rx(pack(8'h77, ROW, COL, 1'b0, 23'h100001), 6);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
